fsm2_stim_gen: RTL and testbench

FSM2_STIM_GEN -- requirements
Module: fsm2_stim_gen

---
 rtl/fsm2_stim_gen.sv | 163 ++++++++++++++++
 tb/tb_fsm2_stim_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm2_stim_gen.sv
// Stimulus generator for a two-input FSM under test: steps through a fixed
// 8-entry (a,b) pattern, holds each step for a programmable number of cycles,
// and compares the FSM's y0/yl responses against expected bit masks.
module fsm2_stim_gen #(
    parameter logic [7:0] EXP_Y0 = 8'h00,
    parameter logic [7:0] EXP_YL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] hold_cycles,
    input  logic       y0_in,
    input  logic       yl_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [2:0] step,
    output logic       mismatch,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] h_q, h_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       mismatch_q, mismatch_d;
    logic [3:0] err_count_q, err_count_d;

    logic       hold_last;
    logic       step_mismatch;

    // Fixed (a,b) stimulus table, returned as {a,b}.
    function automatic logic [1:0] pattern_ab(input logic [2:0] s);
        logic [1:0] ab;
        case (s)
            3'd0:    ab = 2'b11;
            3'd1:    ab = 2'b01;
            3'd2:    ab = 2'b00;
            3'd3:    ab = 2'b10;
            3'd4:    ab = 2'b01;
            3'd5:    ab = 2'b00;
            3'd6:    ab = 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // State and datapath registers; reset returns everything to an idle, clean slate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            hold_cnt_q  <= 4'd0;
            h_q         <= 4'd1;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            err_count_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            hold_cnt_q  <= hold_cnt_d;
            h_q         <= h_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic: start a run, hold/advance steps, score responses, finish.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        hold_cnt_d    = hold_cnt_q;
        h_d           = h_q;
        a_d           = a_q;
        b_d           = b_q;
        busy_d        = busy_q;
        done_d        = done_q;
        mismatch_d    = mismatch_q;
        err_count_d   = err_count_q;
        hold_last     = (hold_cnt_q == (h_q - 4'd1));
        step_mismatch = (y0_in != EXP_Y0[step_q]) || (yl_in != EXP_YL[step_q]);

        case (state_q)
            IDLE: begin
                a_d        = 1'b0;
                b_d        = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                step_d     = 3'd0;
                hold_cnt_d = 4'd0;
                if (start) begin
                    state_d      = DRIVE;
                    {a_d, b_d}   = pattern_ab(3'd0);
                    busy_d       = 1'b1;
                    h_d          = (hold_cycles == 4'd0) ? 4'd1 : hold_cycles;
                    mismatch_d   = 1'b0;
                    err_count_d  = 4'd0;
                end
            end
            DRIVE: begin
                if (hold_last) begin
                    if (step_mismatch) begin
                        mismatch_d = 1'b1;
                        if (err_count_q != 4'd15) begin
                            err_count_d = err_count_q + 4'd1;
                        end
                    end
                    hold_cnt_d = 4'd0;
                    if (step_q == 3'd7) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        step_d     = step_q + 3'd1;
                        {a_d, b_d} = pattern_ab(step_q + 3'd1);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                step_d  = 3'd0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step      = step_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_fsm2_stim_gen.sv
// Self-checking bench for fsm2_stim_gen: two instances (default masks and
// EXP_YL=FF) share stimulus and are compared every cycle against a run-level
// model, plus directed literal checks of latency and error counts.
module tb_fsm2_stim_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hold_cycles = 4'd1;
    logic       y0_in = 1'b0;
    logic       yl_in = 1'b0;

    logic       a0, b0, busy0, done0, mismatch0;
    logic [2:0] step0;
    logic [3:0] err0;
    logic       a1, b1, busy1, done1, mismatch1;
    logic [2:0] step1;
    logic [3:0] err1;

    int  errors = 0;
    int  checks = 0;
    bit  check_en = 1'b0;

    fsm2_stim_gen dut0 (
        .clk(clk), .reset(reset), .start(start), .hold_cycles(hold_cycles),
        .y0_in(y0_in), .yl_in(yl_in), .a(a0), .b(b0), .busy(busy0),
        .done(done0), .step(step0), .mismatch(mismatch0), .err_count(err0)
    );

    fsm2_stim_gen #(.EXP_Y0(8'h00), .EXP_YL(8'hFF)) dut1 (
        .clk(clk), .reset(reset), .start(start), .hold_cycles(hold_cycles),
        .y0_in(y0_in), .yl_in(yl_in), .a(a1), .b(b1), .busy(busy1),
        .done(done1), .step(step1), .mismatch(mismatch1), .err_count(err1)
    );

    always #5 clk = ~clk;

    // Run-level model: a run is "t cycles since the start edge" with hold H.
    bit [1:0] pat [8] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    bit [7:0] m_ey0 [2] = '{8'h00, 8'h00};
    bit [7:0] m_eyl [2] = '{8'h00, 8'hFF};
    bit       m_act [2];
    bit       m_dn  [2];
    int       m_t   [2];
    int       m_h   [2];
    int       m_err [2];
    bit       m_mis [2];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] h, input logic y0, input logic yl);
        hold_cycles = h;
        y0_in       = y0;
        yl_in       = yl;
    endtask

    // Start a run and count edges until done is seen; optionally disturb mid-run.
    task automatic runAndMeasure(input bit disturb, output int latency);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        latency = -1;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (disturb && n == 3) begin
                start = 1'b1;
                hold_cycles = 4'd7;
            end
            if (disturb && n == 4) start = 1'b0;
            if (done0) begin
                latency = n;
                break;
            end
        end
    endtask

    // Model update on every active edge, reading the same inputs the DUTs see.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 1'b0; m_dn[i] = 1'b0; m_t[i] = 0;
                m_err[i] = 0;    m_mis[i] = 1'b0;
            end else if (m_dn[i]) begin
                m_dn[i] = 1'b0;
            end else if (m_act[i]) begin
                m_t[i]++;
                if (m_t[i] % m_h[i] == 0) begin
                    int s;
                    s = m_t[i] / m_h[i] - 1;
                    if (y0_in != m_ey0[i][s] || yl_in != m_eyl[i][s]) begin
                        m_mis[i] = 1'b1;
                        if (m_err[i] < 15) m_err[i]++;
                    end
                    if (m_t[i] == 8 * m_h[i]) begin
                        m_act[i] = 1'b0;
                        m_dn[i]  = 1'b1;
                    end
                end
            end else if (start) begin
                m_act[i] = 1'b1;
                m_t[i]   = 0;
                m_h[i]   = (hold_cycles == 0) ? 1 : int'(hold_cycles);
                m_err[i] = 0;
                m_mis[i] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model, away from the edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [11:0] exp_v, act_v;
                logic [1:0]  ab;
                logic [2:0]  st;
                ab = m_act[i] ? pat[m_t[i] / m_h[i]] : 2'b00;
                st = m_act[i] ? 3'(m_t[i] / m_h[i]) : (m_dn[i] ? 3'd7 : 3'd0);
                exp_v = {ab, m_act[i], m_dn[i], st, m_mis[i], 4'(m_err[i])};
                if (i == 0) act_v = {a0, b0, busy0, done0, step0, mismatch0, err0};
                else        act_v = {a1, b1, busy1, done1, step1, mismatch1, err1};
                checkOutput(i == 0 ? "cycle_dut0{ab,busy,done,step,mis,err}"
                                   : "cycle_dut1{ab,busy,done,step,mis,err}",
                            32'(act_v), 32'(exp_v));
            end
        end
    end

    initial begin
        int lat;
        int n;
        bit seen_done;

        applyStimulus(4'd5, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_outputs", {a0, b0, busy0, done0, step0, mismatch0, err0}, 12'h000);
        reset = 1'b0;

        // Default masks, H=5, responses all zero: 40-cycle clean run.
        applyStimulus(4'd5, 1'b0, 1'b0);
        runAndMeasure(1'b0, lat);
        checkOutput("h5_latency", lat, 40);
        checkOutput("h5_err_count", err0, 4'd0);
        checkOutput("h5_mismatch", mismatch0, 1'b0);
        @(posedge clk); #1;
        checkOutput("h5_after_done", {done0, busy0, step0}, 5'b0);

        // y0 held high: every step mismatches.
        applyStimulus(4'd1, 1'b1, 1'b0);
        runAndMeasure(1'b0, lat);
        checkOutput("h1_latency", lat, 8);
        checkOutput("h1_err_count", err0, 4'd8);
        checkOutput("h1_mismatch", mismatch0, 1'b1);
        @(posedge clk); #1;
        checkOutput("h1_sticky_in_idle", {mismatch0, err0}, 5'h18);

        // hold_cycles=0 behaves as 1.
        applyStimulus(4'd0, 1'b0, 1'b0);
        runAndMeasure(1'b0, lat);
        checkOutput("h0_latency", lat, 8);
        checkOutput("h0_err_count", err0, 4'd0);

        // Reset mid-run at step 3 with H=4.
        applyStimulus(4'd4, 1'b1, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (step0 != 3'd3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reset_reach_step3", step0, 3'd3);
        checkOutput("reset_err_before", err0, 4'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("reset_mid_run", {a0, b0, busy0, step0, err0, mismatch0}, 12'h000);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done0) seen_done = 1'b1;
        end
        checkOutput("reset_no_done", seen_done, 1'b0);

        // Start pulsed mid-run and hold changed 2->7: run keeps H=2.
        applyStimulus(4'd2, 1'b0, 1'b0);
        runAndMeasure(1'b1, lat);
        checkOutput("nostart_latency", lat, 16);
        applyStimulus(4'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Back-to-back runs with start held high on the EXP_YL=FF instance.
        applyStimulus(4'd1, 1'b0, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("b2b_run1_done", done1, 1'b1);
        checkOutput("b2b_run1_err", err1, 4'd8);
        @(posedge clk); #1;
        checkOutput("b2b_idle_gap", {busy1, done1, step1}, 5'b0);
        @(posedge clk); #1;
        checkOutput("b2b_run2_start", {busy1, step1, a1, b1, err1, mismatch1}, {1'b1, 3'd0, 2'b11, 4'd0, 1'b0});
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        checkOutput("b2b_run2_latency", n, 8);
        checkOutput("b2b_run2_err", err1, 4'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("b2b_final_idle", {busy1, done1}, 2'b00);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
